// File: rtl/event_bus_pkg.sv
// Shared types and default sizes for the SoC->cluster event bus.
package event_bus_pkg;

  localparam int DEF_BUFFER_WIDTH = 8;
  localparam int DEF_EVNT_WIDTH   = 8;

  typedef logic [DEF_EVNT_WIDTH-1:0]   evt_word_t;
  typedef logic [DEF_BUFFER_WIDTH-1:0] evt_slot_t;

  typedef enum logic {
    RX_SETTLE,
    RX_WAIT
  } rx_state_e;

endpackage

// File: rtl/event_token_sync.sv
// Per-bit flop-chain synchroniser for the writer's toggle-coded slot tokens.
module event_token_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  // Each bit toggles at most once per slot fill, so independent bit chains are safe.
  logic [STAGES-1:0][WIDTH-1:0] chain_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], async_i};
    end
  end

  assign sync_o = chain_q[STAGES-1];

endmodule

// File: rtl/cluster_event_bus_rx.sv
// Cluster-side reader of the token-ring dual-clock event FIFO; presents events as a valid/ready stream.
module cluster_event_bus_rx
  import event_bus_pkg::*;
#(
  parameter int BUFFER_WIDTH  = DEF_BUFFER_WIDTH,
  parameter int EVNT_WIDTH    = DEF_EVNT_WIDTH,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [BUFFER_WIDTH-1:0] evt_writetoken_i,
  input  logic [EVNT_WIDTH-1:0]   evt_data_async_i,
  output logic [BUFFER_WIDTH-1:0] evt_readpointer_o,
  output logic                    evt_valid_o,
  output logic [EVNT_WIDTH-1:0]   evt_data_o,
  input  logic                    evt_ready_i,
  output logic                    evt_pending_o
);

  localparam int                CNT_W       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

  rx_state_e               state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BUFFER_WIDTH-1:0] phase_q, phase_d;
  logic [BUFFER_WIDTH-1:0] rdptr_q, rdptr_d;
  logic                    valid_q, valid_d;
  logic [EVNT_WIDTH-1:0]   data_q, data_d;
  logic [BUFFER_WIDTH-1:0] tok_s;
  logic                    full_slot;

  event_token_sync #(
    .WIDTH  (BUFFER_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_token_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .async_i (evt_writetoken_i),
    .sync_o  (tok_s)
  );

  // A slot holds an unread word while its synced token differs from the phase of our last lap.
  assign full_slot = |(rdptr_q & (tok_s ^ phase_q));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    rdptr_d = rdptr_q;
    valid_d = valid_q;
    data_d  = data_q;
    if (evt_ready_i) begin
      valid_d = 1'b0;
    end
    case (state_q)
      RX_SETTLE: begin
        // Lets the writer-side mux follow the new pointer before anything is sampled.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = RX_WAIT;
        end
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
      end
      RX_WAIT: begin
        if (full_slot && (!valid_q || evt_ready_i)) begin
          data_d  = evt_data_async_i;
          valid_d = 1'b1;
          phase_d = phase_q ^ rdptr_q;
          rdptr_d = {rdptr_q[BUFFER_WIDTH-2:0], rdptr_q[BUFFER_WIDTH-1]};
          state_d = RX_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
      end
      default: state_d = RX_SETTLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RX_SETTLE;
      cnt_q   <= SETTLE_LOAD;
      phase_q <= '0;
      rdptr_q <= BUFFER_WIDTH'(1);
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      rdptr_q <= rdptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign evt_readpointer_o = rdptr_q;
  assign evt_valid_o       = valid_q;
  assign evt_data_o        = data_q;
  assign evt_pending_o     = full_slot;

  a_rdptr_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot(rdptr_q));

endmodule
